// File: rtl/gf180mcu_fd_sc_mcu9t5v0__seq_pkg.sv
// Shared definitions for the behavioural models of the sequential cells.
//   sel_e       : next-state select encoding (hold / load / shift).
//   encode_sel  : packs the scan enable and load enable into a select word.
//   x_merge     : per-bit two-way select that merges candidates under an
//                 unknown select (agreeing bits keep their value, others go X).
package gf180mcu_fd_sc_mcu9t5v0__seq_pkg;

  // Bit 1 means shift and bit 0 means load. Bit 0 only matters when bit 1
  // is clear, so 2'b11 also decodes as a shift.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_LOAD  = 2'b01,
    SEL_SHIFT = 2'b10
  } sel_e;

  localparam int SEL_LOAD_BIT  = 0;
  localparam int SEL_SHIFT_BIT = 1;

  // The raw enables are kept instead of masking load with ~se. If se is
  // unknown, the merge then happens only between the two real candidates:
  // load-or-hold and shift.
  function automatic logic [1:0] encode_sel(input logic se, input logic en);
    return {se, en};
  endfunction

  // A conditional with an unknown select gives a when a == b and X
  // otherwise. That is exactly the unknown-control rule of the cell models.
  function automatic logic x_merge(input logic s, input logic a, input logic b);
    return s ? b : a;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffq_chain.sv
// One mux-scan chain of L flops with load enable and async active-high reset.
//   CLK, RST  : rising-edge clock, asynchronous active-high reset.
//   EN, D     : functional load enable and data (L bits).
//   SE, SI    : scan enable (priority over EN) and serial scan input.
//   Q         : flop state; Q[0] is the chain head and Q[L-1] is the tail.
//   SO        : scan output, which is the tail flop.
module gf180mcu_fd_sc_mcu9t5v0__sdffq_chain
  import gf180mcu_fd_sc_mcu9t5v0__seq_pkg::*;
#(
  parameter int             L         = 4,
  parameter logic [L-1:0]   RESET_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic         SE,
  input  logic         SI,
  input  logic [L-1:0] D,
  output logic [L-1:0] Q,
  output logic         SO
);

  logic [L-1:0] shifted;
  logic [L-1:0] nxt;
  logic [1:0]   sel;

  // Shift toward the tail: the head takes SI and each bit takes its neighbour.
  generate
    if (L == 1) begin : g_single
      assign shifted = SI;
    end else begin : g_multi
      assign shifted = {Q[L-2:0], SI};
    end
  endgenerate

  assign sel = encode_sel(SE, EN);

  always_comb begin
    nxt = Q;
    for (int i = 0; i < L; i++) begin
      nxt[i] = x_merge(sel[SEL_SHIFT_BIT],
                       x_merge(sel[SEL_LOAD_BIT], Q[i], D[i]),
                       shifted[i]);
    end
  end

  // NOTE: state is updated with non-blocking assignments only. Every flop
  // then samples the pre-edge value of its neighbour, and that is what makes
  // the shift a true shift rather than a ripple through the whole chain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Q <= RESET_VAL;
    else     Q <= nxt;
  end

  assign SO = Q[L-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__sdffq_bank.sv
// Parametrised multi-bit scan flip-flop bank, arranged as CHAINS equal chains.
//   CLK, RST  : rising-edge clock, asynchronous active-high reset.
//   EN, D     : functional load enable and WIDTH-bit data.
//   SE, SI    : scan enable (priority over EN), one scan-in bit per chain.
//   Q         : WIDTH-bit state. Chain c owns bits c*L (head) to c*L+L-1 (tail).
//   SO        : one scan-out bit per chain, equal to that chain's tail bit.
//   VDD, VSS  : power pins, only when USE_POWER_PINS is defined; no function.
module gf180mcu_fd_sc_mcu9t5v0__sdffq_bank #(
  parameter int               WIDTH     = 8,
  parameter int               CHAINS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
`ifdef USE_POWER_PINS
  inout  wire               VDD,
  inout  wire               VSS,
`endif
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [WIDTH-1:0]  D,
  input  logic              SE,
  input  logic [CHAINS-1:0] SI,
  output logic [WIDTH-1:0]  Q,
  output logic [CHAINS-1:0] SO
);

  // The guard keeps the division legal long enough for the config check
  // below to report the real problem.
  localparam int L = WIDTH / ((CHAINS < 1) ? 1 : CHAINS);

  generate
    if (WIDTH < 1 || CHAINS < 1 || (WIDTH % CHAINS) != 0) begin : g_bad_cfg
      $error("sdffq_bank: WIDTH must be >= 1 and a multiple of CHAINS");
    end

    for (genvar c = 0; c < CHAINS; c++) begin : g_chain
      gf180mcu_fd_sc_mcu9t5v0__sdffq_chain #(
        .L         (L),
        .RESET_VAL (RESET_VAL[c*L +: L])
      ) u_chain (
        .CLK (CLK),
        .RST (RST),
        .EN  (EN),
        .SE  (SE),
        .SI  (SI[c]),
        .D   (D[c*L +: L]),
        .Q   (Q[c*L +: L]),
        .SO  (SO[c])
      );
    end
  endgenerate

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__sdffq_bank.sv
// Scoreboard bench for the scan flop bank. The driver applies directed
// vectors and pushes hand-computed expectations. The monitor pops them and
// compares them against the selected DUT instance.
//   unit 0: WIDTH=8, CHAINS=2, RESET_VAL=8'hA5
//   unit 1: WIDTH=4, CHAINS=4, RESET_VAL=0
//   unit 2: WIDTH=1, CHAINS=1, RESET_VAL=0
module tb_gf180mcu_fd_sc_mcu9t5v0__sdffq_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, se;
  logic [7:0] d;
  logic [1:0] si;
  logic [7:0] q;
  logic [1:0] so;

  logic       en4, se4;
  logic [3:0] d4, si4, q4, so4;

  logic       en1, se1, d1, si1, q1, so1;

  gf180mcu_fd_sc_mcu9t5v0__sdffq_bank #(
    .WIDTH(8), .CHAINS(2), .RESET_VAL(8'hA5)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .D(d), .SE(se), .SI(si), .Q(q), .SO(so)
  );

  gf180mcu_fd_sc_mcu9t5v0__sdffq_bank #(
    .WIDTH(4), .CHAINS(4), .RESET_VAL(4'h0)
  ) dut4 (
    .CLK(clk), .RST(rst), .EN(en4), .D(d4), .SE(se4), .SI(si4), .Q(q4), .SO(so4)
  );

  gf180mcu_fd_sc_mcu9t5v0__sdffq_bank #(
    .WIDTH(1), .CHAINS(1), .RESET_VAL(1'b0)
  ) dut1 (
    .CLK(clk), .RST(rst), .EN(en1), .D(d1), .SE(se1), .SI(si1), .Q(q1), .SO(so1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         unit;
    logic [7:0] q;
    logic [7:0] so;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks = 0;
  int   errors = 0;

  task automatic expect_out(input string name, input int unit,
                            input logic [7:0] eq, input logic [7:0] eso);
    exp_t e;
    e.name = name;
    e.unit = unit;
    e.q    = eq;
    e.so   = eso;
    sb.push_back(e);
    -> chk_ev;
  endtask

  // Let one rising edge pass, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: drains every pending expectation when the driver signals
  // that outputs are stable.
  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        exp_t       e;
        logic [7:0] aq, aso;
        e = sb.pop_front();
        case (e.unit)
          0:       begin aq = q;            aso = {6'b0, so};  end
          1:       begin aq = {4'b0, q4};   aso = {4'b0, so4}; end
          default: begin aq = {7'b0, q1};   aso = {7'b0, so1}; end
        endcase
        checks++;
        if (aq !== e.q || aso !== e.so) begin
          errors++;
          $display("FAIL %s: got Q=%h SO=%h, expected Q=%h SO=%h",
                   e.name, aq, aso, e.q, e.so);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] st_si  [4];
    logic [7:0] st_q   [4];
    logic [1:0] st_so  [4];
    logic [7:0] sc_q   [4];
    logic [1:0] sc_so  [4];

    rst = 1'b1; en = 0; se = 0; d = '0; si = '0;
    en4 = 0; se4 = 0; d4 = '0; si4 = '0;
    en1 = 0; se1 = 0; d1 = 0; si1 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    expect_out("por_main", 0, 8'hA5, 8'h02);
    expect_out("por_w4",   1, 8'h00, 8'h00);
    expect_out("por_w1",   2, 8'h00, 8'h00);

    // Preload 3C, then apply an asynchronous reset between edges.
    en = 1; d = 8'h3C;
    tick();
    expect_out("preload_3c", 0, 8'h3C, 8'h01);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 expect_out("async_reset", 0, 8'hA5, 8'h02);
    en = 1; d = 8'hFF;
    tick();
    expect_out("reset_hold_edge1", 0, 8'hA5, 8'h02);
    tick();
    expect_out("reset_hold_edge2", 0, 8'hA5, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    #1 expect_out("reset_fall_no_change", 0, 8'hA5, 8'h02);

    // Load, then hold for three edges.
    en = 1; d = 8'h5A;
    tick();
    expect_out("load_5a", 0, 8'h5A, 8'h01);
    en = 0; d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("hold_%0d", i), 0, 8'h5A, 8'h01);
    end

    // Scan has priority over load, and chain 1 must not see chain 0's data.
    en = 1; d = 8'h00;
    tick();
    expect_out("load_00", 0, 8'h00, 8'h00);
    se = 1; si = 2'b01;
    sc_q  = '{8'h01, 8'h03, 8'h07, 8'h0F};
    sc_so = '{2'b00, 2'b00, 2'b00, 2'b01};
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("scan_prio_%0d", i), 0, sc_q[i], {6'b0, sc_so[i]});
    end

    // Shift-through from the reset pattern: chain 0 gets 1,0,0,0.
    se = 0; en = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 expect_out("reset_before_shift", 0, 8'hA5, 8'h02);
    se = 1;
    st_si = '{2'b01, 2'b00, 2'b00, 2'b00};
    st_q  = '{8'h4B, 8'h86, 8'h0C, 8'h08};
    st_so = '{2'b01, 2'b10, 2'b01, 2'b01};
    for (int i = 0; i < 4; i++) begin
      si = st_si[i];
      tick();
      expect_out($sformatf("shift_thru_%0d", i), 0, st_q[i], {6'b0, st_so[i]});
    end

    // Reset in the middle of a shift sequence.
    se = 0; en = 1; d = 8'h00;
    tick();
    expect_out("midshift_load_00", 0, 8'h00, 8'h00);
    se = 1; si = 2'b11;
    tick();
    expect_out("midshift_edge1", 0, 8'h11, 8'h00);
    tick();
    expect_out("midshift_edge2", 0, 8'h33, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    #1 expect_out("midshift_reset", 0, 8'hA5, 8'h02);
    tick();
    expect_out("midshift_reset_edge", 0, 8'hA5, 8'h02);
    @(negedge clk);
    rst = 1'b0;
    #1 expect_out("midshift_release", 0, 8'hA5, 8'h02);
    tick();
    expect_out("midshift_resume", 0, 8'h5B, 8'h01);
    se = 0; en = 0;

    // Degenerate configurations: every flop is its own chain.
    se4 = 1; si4 = 4'b1010;
    se1 = 1; si1 = 1'b1;
    tick();
    expect_out("w4_c4_shift", 1, 8'h0A, 8'h0A);
    expect_out("w1_c1_shift", 2, 8'h01, 8'h01);
    se4 = 0; en4 = 0; d4 = 4'hF;
    se1 = 0; en1 = 1; d1 = 1'b0;
    tick();
    expect_out("w4_c4_hold", 1, 8'h0A, 8'h0A);
    expect_out("w1_c1_load", 2, 8'h00, 8'h00);

    // Give the monitor a bounded window to drain the queue.
    for (int i = 0; i < 20 && sb.size() > 0; i++) #1;
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
      errors += sb.size();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
